status_uart_reporter: RTL and testbench

- Serial status reporter that drives the board `txd` pin.
- Sits downstream of the clock generator and LED divider logic. Consumes an 8-bit status vector (clock-generator info, reset state, lock flags) and transmits it as an ASCII frame over 8N1 UART.
- Frames are sent periodically, or on an explicit request.
- Gives bring-up visibility of clocking status without a logic analyser.

---
 rtl/status_uart_reporter.sv | 181 ++++++++++++++++++
 tb/tb_status_uart_reporter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/status_uart_reporter.sv
// Periodic / on-request status reporter: sends "S<hi><lo>\r\n" as 8N1 UART.
// Ports: int_clock, int_reset(async low), status, report_request -> txd, busy, frames_sent.
module status_uart_reporter #(
  parameter int baud_divide   = 723,
  parameter int report_period = 83000000
) (
  input  logic       int_clock,
  input  logic       int_reset,
  input  logic [7:0] status,
  input  logic       report_request,
  output logic       txd,
  output logic       busy,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(baud_divide - 1);
  localparam logic [31:0] PER_LAST = 32'(report_period - 1);
  localparam bit          PER_EN   = (report_period != 0);

  state_t      state, state_n;
  logic        pending, pending_n;
  logic [31:0] period_cnt, period_cnt_n;
  logic [15:0] bit_timer, bit_timer_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [7:0]  status_q, status_q_n;
  logic        txd_n, busy_n;
  logic [7:0]  frames_n;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_bit;
  logic        period_hit;
  logic        bit_done;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h37 + 8'(n);
  endfunction

  always_comb begin
    cur_byte = 8'h0A;
    unique case (byte_idx)
      3'd0:    cur_byte = 8'h53;
      3'd1:    cur_byte = hex_char(status_q[7:4]);
      3'd2:    cur_byte = hex_char(status_q[3:0]);
      3'd3:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign nxt_bit  = bit_idx + 3'd1;
  assign bit_done = (bit_timer == BIT_LAST);

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    period_cnt_n = period_cnt;
    bit_timer_n  = bit_timer;
    bit_idx_n    = bit_idx;
    byte_idx_n   = byte_idx;
    status_q_n   = status_q;
    txd_n        = txd;
    busy_n       = busy;
    frames_n     = frames_sent;
    period_hit   = 1'b0;

    // period counter free-runs regardless of frame state
    if (PER_EN) begin
      if (period_cnt == PER_LAST) begin
        period_cnt_n = '0;
        period_hit   = 1'b1;
      end else begin
        period_cnt_n = period_cnt + 32'd1;
      end
    end

    pending_n = pending | report_request | period_hit;

    unique case (state)
      IDLE: begin
        if (pending) begin
          status_q_n  = status;
          pending_n   = 1'b0;
          byte_idx_n  = '0;
          bit_timer_n = '0;
          state_n     = START;
          txd_n       = 1'b0;
          busy_n      = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          bit_timer_n = '0;
          bit_idx_n   = '0;
          state_n     = DATA;
          txd_n       = cur_byte[0];
        end else begin
          bit_timer_n = bit_timer + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = nxt_bit;
            txd_n     = cur_byte[nxt_bit];
          end
        end else begin
          bit_timer_n = bit_timer + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_timer_n = '0;
          if (byte_idx != 3'd4) begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = START;
            txd_n      = 1'b0;
          end else begin
            frames_n = frames_sent + 8'd1;
            // a trigger already pending chains the next frame with no gap
            if (pending) begin
              status_q_n = status;
              pending_n  = 1'b0;
              byte_idx_n = '0;
              state_n    = START;
              txd_n      = 1'b0;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end else begin
          bit_timer_n = bit_timer + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge int_clock or negedge int_reset) begin
    if (!int_reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      period_cnt  <= '0;
      bit_timer   <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      status_q    <= '0;
      txd         <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      period_cnt  <= period_cnt_n;
      bit_timer   <= bit_timer_n;
      bit_idx     <= bit_idx_n;
      byte_idx    <= byte_idx_n;
      status_q    <= status_q_n;
      txd         <= txd_n;
      busy        <= busy_n;
      frames_sent <= frames_n;
    end
  end

endmodule

// File: tb/tb_status_uart_reporter.sv
// Bench for status_uart_reporter: UART receiver monitors check bytes
// against a scoreboard queue filled when each frame is requested.
module tb_status_uart_reporter;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [7:0] status0, status1;
  logic       req0, req1;
  logic       txd0, txd1;
  logic       busy0, busy1;
  logic [7:0] fs0, fs1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  status_uart_reporter #(
    .baud_divide  (BD),
    .report_period(0)
  ) dut0 (
    .int_clock     (clk),
    .int_reset     (rst0),
    .status        (status0),
    .report_request(req0),
    .txd           (txd0),
    .busy          (busy0),
    .frames_sent   (fs0)
  );

  status_uart_reporter #(
    .baud_divide  (BD),
    .report_period(300)
  ) dut1 (
    .int_clock     (clk),
    .int_reset     (rst1),
    .status        (status1),
    .report_request(req1),
    .txd           (txd1),
    .busy          (busy1),
    .frames_sent   (fs1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_of(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_frame(input int sel, input logic [7:0] st);
    logic [7:0] f[5];
    f[0] = 8'h53;
    f[1] = hex_of(st[7:4]);
    f[2] = hex_of(st[3:0]);
    f[3] = 8'h0D;
    f[4] = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      if (sel == 0) exp_q0.push_back(f[i]);
      else exp_q1.push_back(f[i]);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? txd0 : txd1;
  endfunction

  function automatic logic rst_of(input int sel);
    return (sel == 0) ? rst0 : rst1;
  endfunction

  task automatic rx(input int sel);
    logic [7:0]  b;
    logic        ab;
    logic        stp;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (line_of(sel) == 1'b0 && rst_of(sel)) begin
        ab = 1'b0;
        repeat (BD / 2) @(negedge clk);
        if (!rst_of(sel)) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          if (!rst_of(sel)) ab = 1'b1;
          b[i] = line_of(sel);
        end
        repeat (BD) @(negedge clk);
        stp = line_of(sel);
        if (!ab && rst_of(sel)) begin
          check(sel == 0 ? "stop_bit0" : "stop_bit1", {31'h0, stp}, 32'h1);
          e = 'x;
          if (sel == 0 && exp_q0.size() > 0) e = {24'h0, exp_q0.pop_front()};
          if (sel == 1 && exp_q1.size() > 0) e = {24'h0, exp_q1.pop_front()};
          check(sel == 0 ? "rx_byte0" : "rx_byte1", {24'h0, b}, e);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] st, output int blen);
    status0 = st;
    req0    = 1'b1;
    push_frame(0, st);
    @(negedge clk);
    req0 = 1'b0;
    check("pre_txd", {31'h0, txd0}, 32'h1);
    check("pre_busy", {31'h0, busy0}, 32'h0);
    @(negedge clk);
    check("start_txd", {31'h0, txd0}, 32'h0);
    check("start_busy", {31'h0, busy0}, 32'h1);
    blen = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!busy0) break;
      blen++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int blen;
    int bad;
    rst0    = 1'b0;
    rst1    = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    status0 = 8'h00;
    status1 = 8'h12;
    fork
      rx(0);
      rx(1);
    join_none

    repeat (3) @(negedge clk);
    check("rst_txd", {31'h0, txd0}, 32'h1);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_fs", {24'h0, fs0}, 32'h0);
    rst0 = 1'b1;

    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || fs0 !== 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    send_frame(8'h5A, blen);
    check("len_5a", blen, 200);
    check("fs_1", {24'h0, fs0}, 32'd1);
    repeat (3) @(negedge clk);

    send_frame(8'h09, blen);
    check("len_09", blen, 200);
    check("fs_2", {24'h0, fs0}, 32'd2);
    repeat (3) @(negedge clk);

    send_frame(8'hF0, blen);
    check("len_f0", blen, 200);
    check("fs_3", {24'h0, fs0}, 32'd3);
    check("q0_drain_a", exp_q0.size(), 0);
    repeat (3) @(negedge clk);

    // collapse: three mid-frame requests give exactly one chained frame
    status0 = 8'h3C;
    req0    = 1'b1;
    push_frame(0, 8'h3C);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    check("col_start", {31'h0, txd0}, 32'h0);
    blen = 1;
    for (int c = 1; c < 1000; c++) begin
      @(negedge clk);
      req0 = (c == 10 || c == 50 || c == 60);
      if (c == 10) push_frame(0, 8'hE7);
      if (c == 100) status0 = 8'hE7;
      if (!busy0) break;
      blen++;
    end
    req0 = 1'b0;
    check("col_len", blen, 400);
    check("fs_5", {24'h0, fs0}, 32'd5);
    repeat (5) @(negedge clk);
    check("col_idle", {31'h0, busy0}, 32'h0);
    check("q0_drain_b", exp_q0.size(), 0);

    // reset in the data bits of byte 2
    status0 = 8'h77;
    req0    = 1'b1;
    push_frame(0, 8'h77);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    repeat (90) @(negedge clk);
    #2;
    rst0 = 1'b0;
    #1;
    check("mid_rst_txd", {31'h0, txd0}, 32'h1);
    check("mid_rst_busy", {31'h0, busy0}, 32'h0);
    check("mid_rst_fs", {24'h0, fs0}, 32'h0);
    exp_q0.delete();
    repeat (40) @(negedge clk);
    rst0 = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hA5, blen);
    check("len_a5", blen, 200);
    check("fs_after_rst", {24'h0, fs0}, 32'd1);
    repeat (5) @(negedge clk);
    check("q0_drain_c", exp_q0.size(), 0);

    // periodic instance: frames start every 300 cycles
    rst1 = 1'b1;
    for (int k = 1; k <= 850; k++) begin
      @(negedge clk);
      if (k == 299) push_frame(1, status1);
      if (k == 300) check("per1_before", {31'h0, busy1}, 32'h0);
      if (k == 301) begin
        check("per1_busy", {31'h0, busy1}, 32'h1);
        check("per1_txd", {31'h0, txd1}, 32'h0);
      end
      if (k == 350) begin
        status1 = 8'hC4;
        push_frame(1, 8'hC4);
      end
      if (k == 600) check("per2_before", {31'h0, busy1}, 32'h0);
      if (k == 601) check("per2_busy", {31'h0, busy1}, 32'h1);
    end
    check("per_fs", {24'h0, fs1}, 32'd2);
    check("q1_drain", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
